// File: rtl/nonce_uart_tx.sv
// Nonce buffer consumer: fetches a 32-bit nonce serially (LSB first) and sends it as 8N1 UART bytes.
// Optional sync-byte prefix (0xA5) is enabled by defining NONCE_TX_SYNC_BYTE_EN.
`default_nettype none

module nonce_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       newnonce,
    input  logic       nonce_bit,
    input  logic       overflow,
    output logic       read,
    output logic       tx,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef NONCE_TX_SYNC_BYTE_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_TX
    } state_t;

    state_t            state_q;
    logic [31:0]       shreg_q;
    logic [5:0]        bit_q;
    logic [2:0]        byte_q;
    logic [BAUD_W-1:0] baud_q;
    logic              read_q;
    logic              tx_q;
    logic              busy_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;

    logic [7:0]        cur_byte;
    logic              next_tx_bit;

    always_comb begin
        cur_byte = '0;
`ifdef NONCE_TX_SYNC_BYTE_EN
        case (byte_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = shreg_q[7:0];
            3'd2:    cur_byte = shreg_q[15:8];
            3'd3:    cur_byte = shreg_q[23:16];
            default: cur_byte = shreg_q[31:24];
        endcase
`else
        case (byte_q)
            3'd0:    cur_byte = shreg_q[7:0];
            3'd1:    cur_byte = shreg_q[15:8];
            3'd2:    cur_byte = shreg_q[23:16];
            default: cur_byte = shreg_q[31:24];
        endcase
`endif
    end

    // Bit slot b (0 = start, 9 = stop) is followed by data bit b while b < 8, then the stop bit.
    always_comb begin
        next_tx_bit = 1'b1;
        if (bit_q != 6'd8) begin
            next_tx_bit = cur_byte[bit_q[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            baud_q  <= '0;
            read_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    read_q <= 1'b0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (newnonce) begin
                        state_q <= S_FETCH;
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                S_FETCH: begin
                    shreg_q[bit_q[4:0]] <= nonce_bit;
                    if (bit_q == 6'd31) begin
                        state_q <= S_TX;
                        read_q  <= 1'b0;
                        tx_q    <= 1'b0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        baud_q  <= '0;
                    end else begin
                        bit_q <= bit_q + 6'd1;
                    end
                end
                S_TX: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 6'd9) begin
                            if (byte_q == LAST_BYTE) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                tx_q    <= 1'b1;
                            end else begin
                                byte_q <= byte_q + 3'd1;
                                bit_q  <= '0;
                                tx_q   <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 6'd1;
                            tx_q  <= next_tx_bit;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    read_q  <= 1'b0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (overflow && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign read       = read_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign drop_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_uart_tx.sv
// Directed bench for nonce_uart_tx with a serial nonce-buffer model; CLKS_PER_BIT = 4.
module tb_nonce_uart_tx;

    localparam int N = 4;
`ifdef NONCE_TX_SYNC_BYTE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        newnonce = 1'b0;
    logic        nonce_bit;
    logic        overflow = 1'b0;
    logic        read;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_count;

    logic [31:0] buf_q;
    logic [31:0] load_val = '0;
    logic        load_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nonce_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .newnonce   (newnonce),
        .nonce_bit  (nonce_bit),
        .overflow   (overflow),
        .read       (read),
        .tx         (tx),
        .busy       (busy),
        .drop_count (drop_count)
    );

    // Buffer model: rotates right once per read cycle, exposing bit 0.
    assign nonce_bit = buf_q[0];
    always @(posedge clk) begin
        if (read === 1'b1) buf_q <= {buf_q[0], buf_q[31:1]};
        else if (load_en) buf_q <= load_val;
    end

    task automatic load_buf(input logic [31:0] v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic start_nonce(input string name);
        @(negedge clk);
        newnonce = 1'b1;
        @(negedge clk);
        newnonce = 1'b0;
        checks++;
        if ({read, busy} !== 2'b11) begin
            errors++;
            $display("FAIL %s_start: read/busy=%b expected 11", name, {read, busy});
        end
    endtask

    // Entered at the negedge right after TX began; leaves at the negedge after the frame ends.
    task automatic recv_frame(input string name, input logic [31:0] nonce);
        logic [7:0] exp_b [5];
        logic [7:0] got;
        logic       e;
        int         shape_bad;
        int         busy_bad;
        int         idx;
        idx = 0;
`ifdef NONCE_TX_SYNC_BYTE_EN
        exp_b[0] = 8'hA5;
        idx = 1;
`endif
        for (int k = 0; k < 4; k++) exp_b[idx + k] = nonce[8*k +: 8];
        busy_bad = 0;
        for (int b = 0; b < NB; b++) begin
            got = '0;
            shape_bad = 0;
            for (int j = 0; j < 10; j++) begin
                if (j == 0) e = 1'b0;
                else if (j == 9) e = 1'b1;
                else e = exp_b[b][j-1];
                for (int c = 0; c < N; c++) begin
                    if (tx !== e) shape_bad++;
                    if (busy !== 1'b1) busy_bad++;
                    if (c == N/2 && j >= 1 && j <= 8) got[j-1] = tx;
                    @(negedge clk);
                end
            end
            checks++;
            if (got !== exp_b[b]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h expected %h", name, b, got, exp_b[b]);
            end
            checks++;
            if (shape_bad != 0) begin
                errors++;
                $display("FAIL %s_wave%0d: %0d bad samples expected 0", name, b, shape_bad);
            end
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s_busy_during_tx: %0d low samples expected 0", name, busy_bad);
        end
        checks++;
        if ({busy, tx} !== 2'b01) begin
            errors++;
            $display("FAIL %s_end: busy/tx=%b expected 01", name, {busy, tx});
        end
    endtask

    // Entered at the first negedge with read high.
    task automatic fetch_and_send(input string name, input logic [31:0] nonce);
        int cnt;
        cnt = 0;
        while (read === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 32) begin
            errors++;
            $display("FAIL %s_read_len: got %0d expected 32", name, cnt);
        end
        checks++;
        if ({tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL %s_tx_start: tx/busy=%b expected 01", name, {tx, busy});
        end
        recv_frame(name, nonce);
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        newnonce = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if ({tx, read, busy, drop_count} !== {3'b100, 8'h00}) bad++;
        end
        newnonce = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({tx, read, busy, drop_count} !== {3'b100, 8'h00}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles expected 0 (tx/read/busy/cnt=%b/%b/%b/%h)",
                     bad, tx, read, busy, drop_count);
        end
    endtask

    task automatic test_single();
        load_buf(32'h12345678);
        start_nonce("single");
        fetch_and_send("single", 32'h12345678);
        checks++;
        if (buf_q !== 32'h12345678) begin
            errors++;
            $display("FAIL single_buffer_restored: got %h expected 12345678", buf_q);
        end
    endtask

    task automatic test_back_to_back();
        load_buf(32'hFFFFFFFF);
        start_nonce("b2b_a");
        fork
            fetch_and_send("b2b_a", 32'hFFFFFFFF);
            begin
                repeat (60) @(negedge clk);
                load_val = 32'h00000001;
                load_en  = 1'b1;
                newnonce = 1'b1;
                @(negedge clk);
                load_en  = 1'b0;
            end
        join
        checks++;
        if ({read, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle_gap: read/busy=%b expected 00", {read, busy});
        end
        @(negedge clk);
        newnonce = 1'b0;
        checks++;
        if ({read, busy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_second_start: read/busy=%b expected 11", {read, busy});
        end
        fetch_and_send("b2b_b", 32'h00000001);
    endtask

    task automatic test_overflow();
        int cnt;
        load_buf(32'h5A5AA5A5);
        @(negedge clk);
        newnonce = 1'b1;
        overflow = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) newnonce = 1'b0;
            if (i == 100) begin
                checks++;
                if (drop_count !== 8'd100) begin
                    errors++;
                    $display("FAIL ovf_count100: got %0d expected 100", drop_count);
                end
            end
        end
        overflow = 1'b0;
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL ovf_saturate: got %0d expected 255", drop_count);
        end
        @(negedge clk);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL ovf_hold: got %0d expected 255", drop_count);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_frame_done: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_tx();
        int cnt;
        int bad;
        load_buf(32'h89ABCDEF);
        start_nonce("rst");
        cnt = 0;
        while (read === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        repeat (2 * 10 * N + 5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_tx: busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, read, busy, drop_count} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL rst_async: tx/read/busy/cnt=%b/%b/%b/%h expected 1/0/0/00",
                     tx, read, busy, drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (2 * N * 10) begin
            @(negedge clk);
            if ({tx, read, busy} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_partial: %0d bad cycles expected 0", bad);
        end
        load_buf(32'hCAFEF00D);
        start_nonce("rst_after");
        fetch_and_send("rst_after", 32'hCAFEF00D);
    endtask

    task automatic test_deadbeef();
        load_buf(32'hDEADBEEF);
        start_nonce("dbeef");
        fetch_and_send("dbeef", 32'hDEADBEEF);
        checks++;
        if (buf_q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL dbeef_buffer_restored: got %h expected deadbeef", buf_q);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_tx();
        test_deadbeef();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nonce_uart_tx.md
# nonce_uart_tx

Downstream consumer of the nonce buffer. Sees `newnonce`, drives `read` to pull the 32-bit nonce serially out of the buffer LSB first, then sends it to the host over a UART line, 8N1, least-significant byte first. It also counts the overflow events the buffer reports, so the host can tell that nonces were lost.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit; legal range 2 to 65535.

Ports:
- `clk`  input  1: the only clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `newnonce`  input  1: buffer holds an unread nonce.
- `nonce_bit`  input  1: buffer serial output, the current bit 0 of the stored nonce.
- `overflow`  input  1: buffer dropped a nonce this cycle.
- `read`  output  1: held high for exactly 32 consecutive cycles per fetch; the buffer shifts once per cycle while it is high.
- `tx`  output  1: UART line; idles high.
- `busy`  output  1: high in FETCH and TX states.
- `drop_count`  output  8: saturating count of cycles with `overflow` high.

## Operation
State machine, registered outputs:
- IDLE: `read`=0, `tx`=1. If `newnonce`=1, go to FETCH; `read`=1 from the next cycle.
- FETCH: `read`=1 for 32 cycles.
  - Bit counter runs 0..31. At each rising edge with `read`=1, capture `nonce_bit` into shift-register bit k, where k is the counter value. The sampled value is the pre-shift buffer bit, so capture is LSB first.
  - After the 32nd capture, go to TX and drop `read` to 0.
  - 32 shifts rotate the buffer back to its original contents.
- TX: send the frame.
  - Each byte is one start bit (0), 8 data bits LSB first, then one stop bit (1).
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - Byte order: nonce[7:0], [15:8], [23:16], [31:24].
  - After the last stop bit has run its full length, go to IDLE.
- `newnonce` is ignored outside IDLE. Nonces that arrive meanwhile are the buffer's responsibility and show up as `overflow`.
- `drop_count`:
  - Increments by 1 on each cycle with `overflow`=1, in any state.
  - Saturates at 255 and does not wrap.
  - Cleared only by reset.
- Arithmetic widths:
  - Baud counter: $clog2(`CLKS_PER_BIT`) bits, counts 0..CLKS_PER_BIT-1.
  - Bit counter: 6 bits.
  - Byte counter: 3 bits.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `read`=0, `tx`=1, `busy`=0, `drop_count`=0, shift register=0.
- Reset mid-FETCH or mid-TX aborts at once. No partial frame is completed after release.
- Latency from `newnonce` high in IDLE:
  - `read` rises on the next edge.
  - The start bit of byte 0 begins on the edge after the 32nd `read` cycle.
- `busy`:
  - Rises on the same edge as `read`.
  - Falls on the same edge the final stop bit ends.
- Frame length, with `CLKS_PER_BIT`=N:
  - Default: 40·N cycles of TX.
  - With the sync byte enabled: 50·N cycles.
- Back-to-back nonces: the machine spends at least one cycle in IDLE between frames. If `newnonce` is high in that cycle, `read` rises on the next edge.
- Simultaneous events: `overflow` and a state change in the same cycle are independent; the count still increments.

## Configuration
- `NONCE_TX_SYNC_BYTE_EN` defined:
  - Each frame is prefixed by the sync byte 0xA5, sent as a full 8N1 byte before nonce[7:0].
  - The byte counter covers 5 bytes.
- Not defined:
  - 4-byte frames, no sync byte.
  - No sync-byte logic is present.

## Test plan
- Reset, no stimulus: `tx`=1, `read`=0, `busy`=0, `drop_count`=0 throughout.
- Buffer model loaded with 0x12345678, `newnonce` pulse, `CLKS_PER_BIT`=4:
  - `read` high for exactly 32 cycles.
  - `tx` decodes to 0x78, 0x56, 0x34, 0x12.
  - Each bit lasts 4 cycles; `busy` falls 160 cycles after TX entry.
  - Buffer contents are unchanged afterwards.
- Two nonces, 0xFFFFFFFF then 0x00000001, with `newnonce` re-asserted during TX:
  - The second fetch starts only after one IDLE cycle.
  - `tx` carries both frames correctly.
- 300 cycles of `overflow`=1 spread across all states: `drop_count` saturates at 255; a further pulse leaves it at 255.
- `rst_n` asserted in byte 2 of TX: `tx`=1 and `read`=0 immediately; after release, the next `newnonce` produces a full, correct frame.
- With `NONCE_TX_SYNC_BYTE_EN`, nonce 0xDEADBEEF: `tx` decodes to 0xA5, 0xEF, 0xBE, 0xAD, 0xDE; TX lasts 50·N cycles.
